// File: rtl/alu_shift_pkg.sv
// Package for the ALU/shift datapath.
// Holds the ALU and shift encodings and the sequencer state codes.
// The state codes are plain localparams so older code can still compare against them.
package alu_shift_pkg;

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_AND    = 3'b010,
    OP_OR     = 3'b011,
    OP_XOR    = 3'b100,
    OP_NOT_A  = 3'b101,
    OP_PASS_A = 3'b110,
    OP_PASS_M = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_op_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

endpackage

// File: rtl/alu_shift_alu.sv
// Combinational WIDTH-bit ALU.
//   a, m : operands
//   op   : alu_op_e encoding
//   res  : {carry, result}
// Only ADD and SUB drive the carry bit. For SUB the carry is the inverted borrow.
module alu_shift_alu
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] m,
  input  logic [2:0]       op,
  output logic [WIDTH:0]   res
);

  always_comb begin
    res = '0;
    case (op)
      OP_ADD:    res = {1'b0, a} + {1'b0, m};
      OP_SUB:    res = {1'b0, a} + {1'b0, ~m} + {{WIDTH{1'b0}}, 1'b1};
      OP_AND:    res = {1'b0, a & m};
      OP_OR:     res = {1'b0, a | m};
      OP_XOR:    res = {1'b0, a ^ m};
      OP_NOT_A:  res = {1'b0, ~a};
      OP_PASS_A: res = {1'b0, a};
      OP_PASS_M: res = {1'b0, m};
      default:   res = '0;
    endcase
  end

endmodule

// File: rtl/alu_shift_datapath.sv
// ALU/shift/register datapath with a start/busy/done sequencer.
// Flow: operand mux -> ALU -> shifter -> R/Q registers.
// Sequence: IDLE -> EXEC -> (SHIFT) -> WRITE -> IDLE.
//
// Ports:
//   clk, rst_n             clock; asynchronous active-low reset
//   start                  launch an operation (sampled only in IDLE)
//   alu_op, mux_sel        ALU operation; operand M select (0 = b, 1 = R)
//   shift_op, shift_amt    shift kind and shift distance
//   q_en, r_en             commit the result to Q and/or R in WRITE
//   a, b                   operands
//   busy, done             busy while an operation is in flight; done pulses in WRITE
//   q, r                   result registers; R also feeds back as operand M
//   carry, zero            flags of the last completed operation
//
// Build option ALU_SHIFT_BARREL_EN:
//   Defined: EXEC applies the whole shift in one cycle and SHIFT is never entered.
//   Undefined: the shifter moves one position per cycle.
module alu_shift_datapath
  import alu_shift_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         alu_op,
  input  logic               mux_sel,
  input  logic [1:0]         shift_op,
  input  logic [SHAMT_W-1:0] shift_amt,
  input  logic               q_en,
  input  logic               r_en,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   r,
  output logic               carry,
  output logic               zero
);

  logic [1:0]         state;
  logic [2:0]         op_q;
  logic [1:0]         sh_op_q;
  logic [SHAMT_W-1:0] sh_amt_q;
  logic               q_en_q, r_en_q;
  logic [WIDTH-1:0]   a_q, m_q, s;
  logic               carry_tmp;
  logic [WIDTH:0]     alu_res;

  alu_shift_alu #(.WIDTH(WIDTH)) u_alu (
    .a   (a_q),
    .m   (m_q),
    .op  (op_q),
    .res (alu_res)
  );

`ifdef ALU_SHIFT_BARREL_EN
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] x,
                                                input logic [1:0] sop,
                                                input logic [SHAMT_W-1:0] n);
    case (sop)
      SH_LSL:  return x << n;
      SH_LSR:  return x >> n;
      SH_ASR:  return $unsigned($signed(x) >>> n);
      default: return x;
    endcase
  endfunction
`else
  logic [SHAMT_W-1:0] cnt;

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] x,
                                                 input logic [1:0] sop);
    case (sop)
      SH_LSL:  return {x[WIDTH-2:0], 1'b0};
      SH_LSR:  return {1'b0, x[WIDTH-1:1]};
      SH_ASR:  return {x[WIDTH-1], x[WIDTH-1:1]};
      default: return x;
    endcase
  endfunction
`endif

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      sh_op_q   <= '0;
      sh_amt_q  <= '0;
      q_en_q    <= 1'b0;
      r_en_q    <= 1'b0;
      a_q       <= '0;
      m_q       <= '0;
      s         <= '0;
      carry_tmp <= 1'b0;
      q         <= '0;
      r         <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
`ifndef ALU_SHIFT_BARREL_EN
      cnt       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          // Capture everything now, including R as operand M. A later
          // commit to R therefore cannot disturb this operation.
          op_q     <= alu_op;
          sh_op_q  <= shift_op;
          sh_amt_q <= shift_amt;
          q_en_q   <= q_en;
          r_en_q   <= r_en;
          a_q      <= a;
          m_q      <= mux_sel ? r : b;
          state    <= ST_EXEC;
        end
        ST_EXEC: begin
          carry_tmp <= alu_res[WIDTH];
`ifdef ALU_SHIFT_BARREL_EN
          s     <= shift_by(alu_res[WIDTH-1:0], sh_op_q, sh_amt_q);
          state <= ST_WRITE;
`else
          s     <= alu_res[WIDTH-1:0];
          cnt   <= sh_amt_q;
          state <= (sh_op_q == SH_NONE || sh_amt_q == '0) ? ST_WRITE : ST_SHIFT;
`endif
        end
`ifndef ALU_SHIFT_BARREL_EN
        ST_SHIFT: begin
          s   <= shift_one(s, sh_op_q);
          cnt <= cnt - SHAMT_W'(1);
          // The last step happens while cnt is 1, so exactly shift_amt steps run.
          if (cnt == SHAMT_W'(1)) state <= ST_WRITE;
        end
`endif
        ST_WRITE: begin
          if (q_en_q) q <= s;
          if (r_en_q) r <= s;
          carry <= carry_tmp;
          zero  <= (s == '0);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_shift_datapath.sv
// Directed self-checking bench for alu_shift_datapath (WIDTH = 8).
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_alu_shift_datapath;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] alu_op = '0;
  logic       mux_sel = 1'b0;
  logic [1:0] shift_op = '0;
  logic [2:0] shift_amt = '0;
  logic       q_en = 1'b0, r_en = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, carry, zero;
  logic [7:0] q, r;

  int tests = 0;
  int fails = 0;

`ifdef ALU_SHIFT_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  alu_shift_datapath #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op), .mux_sel(mux_sel),
    .shift_op(shift_op), .shift_amt(shift_amt), .q_en(q_en), .r_en(r_en),
    .a(a), .b(b), .busy(busy), .done(done), .q(q), .r(r), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int exp_lat(input logic [1:0] sop, input logic [2:0] amt);
    if (BARREL || sop == 2'b00 || amt == 3'd0) return 2;
    return 2 + int'(amt);
  endfunction

  // Launch one operation, wait for done (bounded) and one more cycle for the commit.
  // lat = -1 on timeout. bcnt counts cycles in which busy was seen.
  task automatic run_op(input logic [2:0] op_i, input logic msel_i, input logic [1:0] sop_i,
                        input logic [2:0] amt_i, input logic qe_i, input logic re_i,
                        input logic [7:0] a_i, input logic [7:0] b_i,
                        output int lat, output int bcnt);
    @(negedge clk);
    alu_op = op_i; mux_sel = msel_i; shift_op = sop_i; shift_amt = amt_i;
    q_en = qe_i; r_en = re_i; a = a_i; b = b_i; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1; bcnt = 0;
    for (int i = 1; i <= 40; i++) begin
      if (busy) bcnt++;
      if (done) begin lat = i; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b exp 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b exp 0", done); end
    tests++; if (q !== 8'h00 || r !== 8'h00) begin fails++; $display("FAIL reset_qr: got q=%h r=%h exp 00 00", q, r); end
    tests++; if (carry !== 1'b0 || zero !== 1'b0) begin fails++; $display("FAIL reset_flags: got c=%b z=%b exp 0 0", carry, zero); end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat, bc;
    run_op(3'd0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 8'h0F, 8'h01, lat, bc);
    tests++; if (lat !== 2) begin fails++; $display("FAIL add_latency: got %0d exp 2", lat); end
    tests++; if (q !== 8'h10) begin fails++; $display("FAIL add_q: got %h exp 10", q); end
    tests++; if (carry !== 1'b0 || zero !== 1'b0) begin fails++; $display("FAIL add_flags: got c=%b z=%b exp 0 0", carry, zero); end
    tests++; if (r !== 8'h00) begin fails++; $display("FAIL add_r_hold: got %h exp 00", r); end
    run_op(3'd0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 8'hF0, 8'h10, lat, bc);
    tests++; if (q !== 8'h00) begin fails++; $display("FAIL add_wrap_q: got %h exp 00", q); end
    tests++; if (carry !== 1'b1 || zero !== 1'b1) begin fails++; $display("FAIL add_wrap_flags: got c=%b z=%b exp 1 1", carry, zero); end
  endtask

  task automatic test_shift_asr();
    int lat, bc;
    run_op(3'd6, 1'b0, 2'd3, 3'd3, 1'b0, 1'b1, 8'h81, 8'h00, lat, bc);
    tests++; if (bc !== (BARREL ? 2 : 5)) begin fails++; $display("FAIL asr_busy_cycles: got %0d exp %0d", bc, BARREL ? 2 : 5); end
    tests++; if (r !== 8'hF0) begin fails++; $display("FAIL asr_r: got %h exp F0", r); end
    tests++; if (q !== 8'h00) begin fails++; $display("FAIL asr_q_hold: got %h exp 00", q); end
    tests++; if (carry !== 1'b0 || zero !== 1'b0) begin fails++; $display("FAIL asr_flags: got c=%b z=%b exp 0 0", carry, zero); end
  endtask

  typedef struct {
    logic [2:0] op; logic [1:0] sop; logic [2:0] amt;
    logic [7:0] a; logic [7:0] b; logic [7:0] q; logic c;
  } vec_t;

  task automatic test_ops_table();
    vec_t v[12];
    int lat, bc;
    v[0]  = '{3'd6, 2'd1, 3'd1, 8'h81, 8'h00, 8'h02, 1'b0}; // PASS A, LSL 1
    v[1]  = '{3'd6, 2'd2, 3'd4, 8'hF0, 8'h00, 8'h0F, 1'b0}; // PASS A, LSR 4
    v[2]  = '{3'd5, 2'd1, 3'd0, 8'h0F, 8'h00, 8'hF0, 1'b0}; // NOT A, LSL by 0
    v[3]  = '{3'd4, 2'd0, 3'd5, 8'hAA, 8'hFF, 8'h55, 1'b0}; // XOR, no shift (amt ignored)
    v[4]  = '{3'd2, 2'd0, 3'd0, 8'h3C, 8'h0F, 8'h0C, 1'b0}; // AND
    v[5]  = '{3'd3, 2'd0, 3'd0, 8'h30, 8'h03, 8'h33, 1'b0}; // OR
    v[6]  = '{3'd7, 2'd0, 3'd0, 8'h11, 8'h5A, 8'h5A, 1'b0}; // PASS M
    v[7]  = '{3'd6, 2'd2, 3'd7, 8'h80, 8'h00, 8'h01, 1'b0}; // PASS A, LSR 7 (max)
    v[8]  = '{3'd1, 2'd0, 3'd0, 8'h05, 8'h07, 8'hFE, 1'b0}; // SUB with borrow
    v[9]  = '{3'd1, 2'd0, 3'd0, 8'h07, 8'h07, 8'h00, 1'b1}; // SUB equal
    v[10] = '{3'd0, 2'd2, 3'd1, 8'hC0, 8'h60, 8'h10, 1'b1}; // ADD carry, then LSR 1
    v[11] = '{3'd1, 2'd3, 3'd1, 8'h00, 8'h02, 8'hFF, 1'b0}; // SUB, then ASR 1
    for (int i = 0; i < 12; i++) begin
      run_op(v[i].op, 1'b0, v[i].sop, v[i].amt, 1'b1, 1'b0, v[i].a, v[i].b, lat, bc);
      tests++;
      if (q !== v[i].q || carry !== v[i].c || zero !== (v[i].q == 8'h00) || lat !== exp_lat(v[i].sop, v[i].amt)) begin
        fails++;
        $display("FAIL op_vec%0d: got q=%h c=%b z=%b lat=%0d exp q=%h c=%b z=%b lat=%0d",
                 i, q, carry, zero, lat, v[i].q, v[i].c, v[i].q == 8'h00, exp_lat(v[i].sop, v[i].amt));
      end
    end
  endtask

  task automatic test_sub_feedback();
    int lat, bc;
    run_op(3'd6, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1, 8'h05, 8'h00, lat, bc);
    tests++; if (r !== 8'h05) begin fails++; $display("FAIL fb_load_r: got %h exp 05", r); end
    run_op(3'd1, 1'b1, 2'd0, 3'd0, 1'b1, 1'b0, 8'h07, 8'hFF, lat, bc);
    tests++; if (q !== 8'h02 || carry !== 1'b1) begin fails++; $display("FAIL fb_sub: got q=%h c=%b exp 02 1", q, carry); end
    tests++; if (r !== 8'h05) begin fails++; $display("FAIL fb_r_hold: got %h exp 05", r); end
    run_op(3'd0, 1'b1, 2'd0, 3'd0, 1'b0, 1'b1, 8'h01, 8'hFF, lat, bc);
    tests++; if (r !== 8'h06) begin fails++; $display("FAIL fb_r_update: got %h exp 06", r); end
  endtask

  task automatic test_no_commit();
    int lat, bc;
    run_op(3'd0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 8'hF0, 8'h10, lat, bc);
    tests++; if (q !== 8'h02 || r !== 8'h06) begin fails++; $display("FAIL nocommit_hold: got q=%h r=%h exp 02 06", q, r); end
    tests++; if (carry !== 1'b1 || zero !== 1'b1) begin fails++; $display("FAIL nocommit_flags: got c=%b z=%b exp 1 1", carry, zero); end
  endtask

  task automatic test_back_to_back();
    int lat, ndone;
    @(negedge clk);
    alu_op = 3'd6; mux_sel = 1'b0; shift_op = 2'd1; shift_amt = 3'd3;
    q_en = 1'b1; r_en = 1'b0; a = 8'h11; b = 8'h00; start = 1'b1;
    @(negedge clk);
    a = 8'h22;  // start stays high for the whole operation
    lat = -1; ndone = 0;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin ndone++; lat = i; break; end
      @(negedge clk);
    end
    tests++; if (lat !== exp_lat(2'd1, 3'd3)) begin fails++; $display("FAIL b2b_latency: got %0d exp %0d", lat, exp_lat(2'd1, 3'd3)); end
    @(negedge clk);
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL b2b_write_start_ignored: got busy=%b done=%b exp 0 0", busy, done); end
    tests++; if (q !== 8'h88) begin fails++; $display("FAIL b2b_first_q: got %h exp 88", q); end
    a = 8'h33; shift_op = 2'd0;
    @(negedge clk);
    start = 1'b0;
    tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL b2b_accept: got busy=%b done=%b exp 1 0", busy, done); end
    @(negedge clk);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_second_done: got %b exp 1", done); end
    @(negedge clk);
    tests++; if (q !== 8'h33 || ndone !== 1) begin fails++; $display("FAIL b2b_second_q: got q=%h ndone=%0d exp 33 1", q, ndone); end
  endtask

  task automatic test_reset_mid_shift();
    int lat, bc;
    @(negedge clk);
    alu_op = 3'd6; mux_sel = 1'b0; shift_op = 2'd3; shift_amt = 3'd3;
    q_en = 1'b1; r_en = 1'b1; a = 8'h81; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL midrst_ctrl: got busy=%b done=%b exp 0 0", busy, done); end
    tests++; if (q !== 8'h00 || r !== 8'h00) begin fails++; $display("FAIL midrst_qr: got q=%h r=%h exp 00 00", q, r); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 8'h03, 8'h04, lat, bc);
    tests++; if (q !== 8'h07 || lat !== 2 || r !== 8'h00) begin fails++; $display("FAIL midrst_recover: got q=%h r=%h lat=%0d exp 07 00 2", q, r, lat); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_shift_asr();
    test_ops_table();
    test_sub_feedback();
    test_no_commit();
    test_back_to_back();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
